// File: rtl/vga_tile_renderer_if.sv
// vga_tile_renderer_if: processor-side bus of the tile renderer
//  iWrEn/iWrAddr/iWrData  map write port (address = row*GRID_W+col)
//  iRdAddr/oRdData        map readback, 1-cycle latency
//  iPalWe/iPalIdx/iPalRgb palette write, iPalRgb = {b,g,r}
//  iClrStart/iClrVal      start a whole-map clear to iClrVal
//  oClrBusy               clear engine running
interface vga_tile_renderer_if #(parameter int AW = 12);
  logic          iWrEn;
  logic [AW-1:0] iWrAddr;
  logic [3:0]    iWrData;
  logic [AW-1:0] iRdAddr;
  logic [3:0]    oRdData;
  logic          iPalWe;
  logic [3:0]    iPalIdx;
  logic [23:0]   iPalRgb;
  logic          iClrStart;
  logic [3:0]    iClrVal;
  logic          oClrBusy;
  modport master (
    output iWrEn, iWrAddr, iWrData, iRdAddr, iPalWe, iPalIdx, iPalRgb, iClrStart, iClrVal,
    input  oRdData, oClrBusy
  );
  modport slave (
    input  iWrEn, iWrAddr, iWrData, iRdAddr, iPalWe, iPalIdx, iPalRgb, iClrStart, iClrVal,
    output oRdData, oClrBusy
  );
endinterface

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: tile-map VGA front end with palette, map readback and clear engine
//  iVGA_CLK          pixel clock, everything synchronous to it
//  iRST_n            asynchronous active-low reset
//  bus (slave)       map write/readback, palette write, clear start/value/busy
//  oHS/oVS           active-low syncs, aligned with colour
//  oBLANK_n          high on visible pixels, aligned with colour
//  oR/oG/oB          pixel colour
//  oFrameStart       1-cycle pulse with the first visible pixel of a frame
//  oVBlank           high while the line counter is past the active area (undelayed)
module vga_tile_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int TILE = 10,
  parameter int GRID_W = 64,
  parameter int GRID_H = 48,
  parameter int AW = 12,
  parameter logic [3:0] BORDER = 4'd0
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  vga_tile_renderer_if.slave bus,
  output logic               oHS,
  output logic               oVS,
  output logic               oBLANK_n,
  output logic [7:0]         oR,
  output logic [7:0]         oG,
  output logic [7:0]         oB,
  output logic               oFrameStart,
  output logic               oVBlank
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int N = GRID_W * GRID_H;
  localparam int HW = $clog2(H_TOT + 1);
  localparam int VW = $clog2(V_TOT + 1);
  localparam int TW = TILE > 1 ? $clog2(TILE) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TW-1:0] T_LAST = TW'(TILE - 1);
  localparam logic [15:0] G_W = 16'(GRID_W);
  localparam logic [15:0] G_H = 16'(GRID_H);
  localparam logic [AW:0] N_CELLS = AW1'(N);
  localparam logic [AW-1:0] N_LAST = AW'(N - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [TW-1:0] px_q, px_d, py_q, py_d;
  logic [15:0]   col_q, col_d, row_q, row_d;
  logic          h_wrap, v_wrap, px_wrap, py_wrap;
  logic          in_grid;
  logic [AW-1:0] vid_addr;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d, ing1_q, ing1_d, fs1_q, fs1_d;
  logic          hs2_q, hs2_d, vs2_q, vs2_d, vis2_q, vis2_d, fs2_q, fs2_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [23:0]   pal_q [16];
  logic [23:0]   pal_d [16];
  logic [3:0]    map_mem [2**AW];
  logic [3:0]    map_px_q, rd_q;
  logic          map_we, clr_we;
  logic [AW-1:0] map_wa;
  logic [3:0]    map_wd;
  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic [3:0]    clr_val_q;
  logic          busy_q;
  // Tile coordinates are tracked by counters alongside hcnt/vcnt, so the map
  // address needs only a constant multiply rather than a divide.
  always_comb begin
    h_wrap   = hcnt_q == H_LAST;
    v_wrap   = vcnt_q == V_LAST;
    px_wrap  = px_q == T_LAST;
    py_wrap  = py_q == T_LAST;
    hcnt_d   = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d   = !h_wrap ? vcnt_q : v_wrap ? '0 : vcnt_q + 1'b1;
    px_d     = h_wrap || px_wrap ? '0 : px_q + 1'b1;
    col_d    = h_wrap ? '0 : col_q + 16'(px_wrap);
    py_d     = !h_wrap ? py_q : v_wrap || py_wrap ? '0 : py_q + 1'b1;
    row_d    = !h_wrap ? row_q : v_wrap ? '0 : row_q + 16'(py_wrap);
    in_grid  = col_q < G_W && row_q < G_H;
    vid_addr = in_grid ? AW'(row_q) * AW'(GRID_W) + AW'(col_q) : '0;
    hs1_d    = !(hcnt_q >= HS_ON && hcnt_q < HS_OFF);
    vs1_d    = !(vcnt_q >= VS_ON && vcnt_q < VS_OFF);
    vis1_d   = hcnt_q < H_VIS && vcnt_q < V_VIS;
    ing1_d   = in_grid;
    fs1_d    = hcnt_q == '0 && vcnt_q == '0;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    vis2_d   = vis1_q;
    fs2_d    = fs1_q;
    rgb_d    = !vis1_q ? '0 : pal_q[ing1_q ? map_px_q : BORDER];
    pal_d    = pal_q;
    if (bus.iPalWe) pal_d[bus.iPalIdx] = bus.iPalRgb;
  end
  // The clear engine owns the write port while busy; a user write in the
  // same cycle as a clear start is dropped, as are out-of-map addresses.
  always_comb begin
    clr_we = state_q == CLEAR;
    map_we = clr_we || (bus.iWrEn && !bus.iClrStart && {1'b0, bus.iWrAddr} < N_CELLS);
    map_wa = clr_we ? ptr_q : bus.iWrAddr;
    map_wd = clr_we ? clr_val_q : bus.iWrData;
  end
  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      px_q   <= '0;
      py_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vis1_q <= 1'b0;
      ing1_q <= 1'b0;
      fs1_q  <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      vis2_q <= 1'b0;
      fs2_q  <= 1'b0;
      rgb_q  <= '0;
      pal_q  <= '{default: '0};
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      px_q   <= px_d;
      py_q   <= py_d;
      col_q  <= col_d;
      row_q  <= row_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      vis1_q <= vis1_d;
      ing1_q <= ing1_d;
      fs1_q  <= fs1_d;
      hs2_q  <= hs2_d;
      vs2_q  <= vs2_d;
      vis2_q <= vis2_d;
      fs2_q  <= fs2_d;
      rgb_q  <= rgb_d;
      pal_q  <= pal_d;
    end
  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      clr_val_q <= '0;
      busy_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.iClrStart) begin
        state_q   <= CLEAR;
        ptr_q     <= '0;
        clr_val_q <= bus.iClrVal;
        busy_q    <= 1'b1;
      end
    end else begin
      ptr_q <= ptr_q + 1'b1;
      if (ptr_q == N_LAST) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  // Map RAM is not reset; reads see the pre-write contents of a same-cycle write.
  always_ff @(posedge iVGA_CLK) begin
    if (map_we) map_mem[map_wa] <= map_wd;
    map_px_q <= map_mem[vid_addr];
    rd_q     <= map_mem[bus.iRdAddr];
  end
  assign bus.oRdData  = rd_q;
  assign bus.oClrBusy = busy_q;
  assign oHS          = hs2_q;
  assign oVS          = vs2_q;
  assign oBLANK_n     = vis2_q;
  assign oFrameStart  = fs2_q;
  assign {oB, oG, oR} = rgb_q;
  assign oVBlank      = vcnt_q >= V_VIS;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: randomized self-checking bench against a pixel-position reference model
module tb_vga_tile_renderer;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int T = 4, GW = 8, GH = 5, AW = 6;
  localparam logic [3:0] BORDER = 4'd9;
  localparam int H_TOT = HA + HF + HS + HB;
  localparam int V_TOT = VA + VF + VS + VB;
  localparam int N = GW * GH;
  logic clk = 1'b0;
  logic iRST_n;
  logic oHS, oVS, oBLANK_n, oFrameStart, oVBlank;
  logic [7:0] oR, oG, oB;
  logic [3:0] map_m [N];
  logic [23:0] pal_m [16];
  int n_vec = 0, n_err = 0, cyc = 0, skip = 0;
  bit colour_en = 1'b1;
  vga_tile_renderer_if #(.AW(AW)) bus ();
  vga_tile_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TILE(T), .GRID_W(GW), .GRID_H(GH), .AW(AW), .BORDER(BORDER)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(iRST_n), .bus(bus),
    .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n), .oR(oR), .oG(oG), .oB(oB),
    .oFrameStart(oFrameStart), .oVBlank(oVBlank)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [23:0] pixel(input int x, input int y);
    if (x / T < GW && y / T < GH) return pal_m[map_m[(y / T) * GW + x / T]];
    return pal_m[BORDER];
  endfunction
  // cyc counts edges since reset release; the colour output after edge k
  // belongs to raster position k-2, while oVBlank follows position k.
  task automatic check_video();
    int p, h, v;
    bit vis;
    chk("vblank", 32'(oVBlank), 32'((cyc / H_TOT) % V_TOT >= VA));
    if (cyc < 2) begin
      chk("hs_rst", 32'(oHS), 1);
      chk("vs_rst", 32'(oVS), 1);
      chk("blank_rst", 32'(oBLANK_n), 0);
      chk("fs_rst", 32'(oFrameStart), 0);
      chk("rgb_rst", 32'({oB, oG, oR}), 0);
    end else begin
      p = cyc - 2;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      vis = h < HA && v < VA;
      chk("hs", 32'(oHS), 32'(!(h >= HA + HF && h < HA + HF + HS)));
      chk("vs", 32'(oVS), 32'(!(v >= VA + VF && v < VA + VF + VS)));
      chk("blank_n", 32'(oBLANK_n), 32'(vis));
      chk("frame_start", 32'(oFrameStart), 32'(h == 0 && v == 0));
      if (!vis) chk("rgb_blank", 32'({oB, oG, oR}), 0);
      else if (colour_en && skip == 0) chk("rgb", 32'({oB, oG, oR}), 32'(pixel(h, v)));
    end
    if (skip > 0) skip--;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_video();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic cyc_op(input bit we, input int wa, input logic [3:0] wd, input int ra);
    logic [3:0] exp;
    exp = map_m[ra];
    bus.iWrEn = we;
    bus.iWrAddr = AW'(wa);
    bus.iWrData = wd;
    bus.iRdAddr = AW'(ra);
    if (we && wa < N) begin
      map_m[wa] = wd;
      skip = 2;
    end
    step();
    bus.iWrEn = 1'b0;
    bus.iPalWe = 1'b0;
    chk("rd_data", 32'(bus.oRdData), 32'(exp));
  endtask
  task automatic pal_op(input logic [3:0] idx, input logic [23:0] rgb);
    bus.iPalWe = 1'b1;
    bus.iPalIdx = idx;
    bus.iPalRgb = rgb;
    pal_m[idx] = rgb;
    skip = 2;
    step();
    bus.iPalWe = 1'b0;
  endtask
  task automatic readback_all();
    for (int a = 0; a < N; a++) begin
      bus.iRdAddr = AW'(a);
      step();
      chk("readback", 32'(bus.oRdData), 32'(map_m[a]));
    end
  endtask
  task automatic do_clear(input logic [3:0] val, input bit with_wr);
    int busy_cnt = 0;
    colour_en = 1'b0;
    bus.iClrStart = 1'b1;
    bus.iClrVal = val;
    bus.iWrEn = with_wr;
    bus.iWrAddr = AW'(1);
    bus.iWrData = ~val;
    step();
    bus.iClrStart = 1'b0;
    bus.iWrEn = 1'b0;
    for (int i = 0; i < N + 8 && bus.oClrBusy; i++) begin
      busy_cnt++;
      bus.iWrEn = i == 5;
      bus.iClrStart = i == 5;
      bus.iWrAddr = AW'(2);
      bus.iWrData = ~val;
      bus.iClrVal = ~val;
      step();
    end
    bus.iWrEn = 1'b0;
    bus.iClrStart = 1'b0;
    chk("clr_busy_len", 32'(busy_cnt), 32'(N));
    for (int a = 0; a < N; a++) map_m[a] = val;
    colour_en = 1'b1;
    skip = 2;
  endtask
  initial begin
    int wa;
    logic [3:0] pidx;
    logic [23:0] prgb;
    bus.iWrEn = 1'b0;
    bus.iWrAddr = '0;
    bus.iWrData = '0;
    bus.iRdAddr = '0;
    bus.iPalWe = 1'b0;
    bus.iPalIdx = '0;
    bus.iPalRgb = '0;
    bus.iClrStart = 1'b0;
    bus.iClrVal = '0;
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
    for (int a = 0; a < N; a++) map_m[a] = '0;
    iRST_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", 32'(oHS), 1);
    chk("rst_vs", 32'(oVS), 1);
    chk("rst_blank", 32'(oBLANK_n), 0);
    chk("rst_rgb", 32'({oB, oG, oR}), 0);
    chk("rst_fs", 32'(oFrameStart), 0);
    chk("rst_busy", 32'(bus.oClrBusy), 0);
    chk("rst_vblank", 32'(oVBlank), 0);
    iRST_n = 1'b1;
    cyc = 0;
    do_clear(4'($urandom), 1'b1);
    readback_all();
    cyc_op(1'b1, 7, 4'd1, 0);
    cyc_op(1'b1, 7, 4'd4, 7);
    cyc_op(1'b0, 0, 4'd0, 7);
    cyc_op(1'b1, N, 4'hF, 0);
    cyc_op(1'b1, 63, 4'hE, 0);
    readback_all();
    pal_op(4'd3, 24'h00FF00);
    cyc_op(1'b1, 0, 4'd3, 0);
    pal_op(4'd5, 24'hFFFFFF);
    cyc_op(1'b1, N - 1, 4'd5, 0);
    pal_op(BORDER, 24'($urandom));
    step();
    for (int i = 0; i < H_TOT * V_TOT + 4 && !oFrameStart; i++) step();
    chk("fs_seen", 32'(oFrameStart), 1);
    chk("px00_green", 32'({oB, oG, oR}), 32'h00FF00);
    run(H_TOT * V_TOT);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        pidx = 4'($urandom);
        prgb = 24'($urandom);
        bus.iPalWe = 1'b1;
        bus.iPalIdx = pidx;
        bus.iPalRgb = prgb;
        pal_m[pidx] = prgb;
        skip = 2;
      end
      wa = int'($urandom_range(0, 63));
      cyc_op($urandom_range(0, 7) == 0, wa, 4'($urandom), int'($urandom_range(0, N - 1)));
    end
    run(H_TOT * V_TOT);
    for (int i = 0; i < H_TOT && cyc % H_TOT != 20; i++) step();
    chk("align", 32'(cyc % H_TOT), 20);
    colour_en = 1'b0;
    bus.iClrStart = 1'b1;
    bus.iClrVal = 4'hA;
    step();
    bus.iClrStart = 1'b0;
    run(9);
    chk("busy_mid_clear", 32'(bus.oClrBusy), 1);
    #1 iRST_n = 1'b0;
    #1;
    chk("arst_hs", 32'(oHS), 1);
    chk("arst_vs", 32'(oVS), 1);
    chk("arst_blank", 32'(oBLANK_n), 0);
    chk("arst_rgb", 32'({oB, oG, oR}), 0);
    chk("arst_fs", 32'(oFrameStart), 0);
    chk("arst_busy", 32'(bus.oClrBusy), 0);
    chk("arst_vblank", 32'(oVBlank), 0);
    @(posedge clk);
    #1;
    iRST_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 16; i++) pal_m[i] = '0;
    colour_en = 1'b1;
    skip = 0;
    step();
    chk("busy_after_rst", 32'(bus.oClrBusy), 0);
    run(H_TOT + 4);
    do_clear(4'($urandom), 1'b0);
    readback_all();
    for (int i = 0; i < 16; i++) pal_op(4'(i), 24'($urandom));
    run(H_TOT * V_TOT / 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
